uart_alu_sequencer: RTL and testbench
=====================================

Name: uart_alu_sequencer

Overview:
- Parametrised command sequencer between the UART RX/TX FIFOs and the ALU; successor to the single-byte operand interface.
- Assembles multi-byte operands A and B, little-endian, plus one opcode byte from the RX FIFO, then commits them atomically to the ALU.
- Captures the ALU result and streams it back to the TX FIFO byte by byte.
- Adds an inter-byte timeout with frame abort, TX backpressure handling, and busy/error status.

Parameters:
- DATA_W, 8, operand/result width in bits; multiple of 8, range 8..32; NBYTES = DATA_W/8.
- OP_W, 6, opcode width in bits (≤8); taken from the low bits of the opcode byte.
- TIMEOUT, 50000, max idle cycles between bytes of one frame; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- i_rx_data  input  8  RX FIFO head byte, valid while i_rx_empty=0 (show-ahead)
- i_rx_empty  input  1  RX FIFO empty
- o_rd  output  1  RX FIFO pop, one-cycle pulse
- i_tx_full  input  1  TX FIFO full
- o_wr  output  1  TX FIFO push, one-cycle pulse
- o_tx_data  output  8  byte pushed when o_wr=1
- i_result  input  DATA_W  combinational ALU result for o_op_a/o_op_b/o_op_code
- o_op_a  output  DATA_W  committed operand A
- o_op_b  output  DATA_W  committed operand B
- o_op_code  output  OP_W  committed opcode
- o_busy  output  1  frame in progress: high from the first accepted byte until the last result byte is pushed
- o_frame_err  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset, asynchronous and immediate:
  - state=RX_A; byte counter=0; timeout counter=0.
  - Staging and committed registers all 0.
  - o_rd, o_wr, o_busy and o_frame_err = 0; o_tx_data = 0.
- All outputs are registered or decoded from the registered state only. No combinational path from inputs to o_rd/o_wr.
- RX pop rule:
  - In RX_A, RX_B and RX_OP, when i_rx_empty=0 the block asserts o_rd for exactly one cycle and captures i_rx_data that same cycle.
  - The next pop is allowed no earlier than the following cycle (one byte per 2 cycles maximum). This avoids popping stale show-ahead data.
- States:
  - RX_A: receives NBYTES bytes into stage_a, LSB first (byte k → bits [8k+7:8k]). After byte NBYTES-1, go to RX_B and clear the byte counter.
  - RX_B: same as RX_A, into stage_b; then go to RX_OP.
  - RX_OP: one byte; stage_op = byte[OP_W-1:0], upper bits ignored. On capture, commit in the same edge: o_op_a←stage_a, o_op_b←stage_b, o_op_code←stage_op. Go to CALC.
  - CALC: exactly one cycle. Latch i_result into res_reg (the ALU sees the committed operands for a full cycle). Go to TX.
  - TX: send res_reg byte k (LSB first), k=0..NBYTES-1.
    - For each byte: when i_tx_full=0, pulse o_wr with o_tx_data=res_reg[8k+7:8k], then advance k.
    - While i_tx_full=1, hold o_wr=0, keep k, and keep o_tx_data stable.
    - After the last push, go to RX_A, set o_busy=0, and clear the counters.
- Committed outputs change only at the RX_OP commit. They hold their value during a partial frame, through an abort, and while RX_A waits.
- Latency for DATA_W=8 with a non-empty FIFO: earliest o_wr is 2 cycles after the opcode pop (CALC, then TX).
- Timeout (TIMEOUT>0):
  - Counter clears on every pop.
  - It increments each cycle spent in RX_A/RX_B/RX_OP without a pop, once at least one byte of the current frame has been accepted.
  - An idle RX_A at a frame start never times out.
  - When the counter equals TIMEOUT-1 and no pop occurs that cycle:
    - pulse o_frame_err;
    - go to RX_A;
    - clear the byte and timeout counters and o_busy;
    - discard the staging registers' contents (they are not committed).
  - If a pop and expiry coincide, the pop wins and there is no abort.
  - CALC and TX never time out; TX stalls indefinitely on i_tx_full.
- TIMEOUT=0: the block waits forever in any RX state; o_frame_err is never asserted.
- Reset mid-frame or mid-TX: immediate return to the reset state. Partially sent result bytes are not resent.
- Counter width is derived from TIMEOUT (clog2, minimum 1) and from NBYTES.

Test Plan:
- DATA_W=8, OP_W=6: RX bytes 0x05, 0x03, 0x20; ALU stub = a+b → o_op_a=0x05, o_op_b=0x03, o_op_code=6'h20; exactly one o_wr with o_tx_data=0x08; o_busy falls after that push.
- DATA_W=16: bytes 0x34, 0x12, 0x01, 0x00, 0xE0; stub a+b → o_op_a=0x1234, o_op_b=0x0001, o_op_code=6'h20 (upper opcode bits dropped); pushes 0x35 then 0x12.
- TX backpressure: hold i_tx_full=1 for 10 cycles entering TX → no o_wr and o_tx_data stable; release → single push of the correct byte, no duplicates.
- Timeout: TIMEOUT=16; send 0x05 only, FIFO then empty → o_frame_err pulses 16 cycles after the pop; o_op_a unchanged from the previous frame; next full frame 0x02, 0x02, 0x20 → result 0x04.
- Coincidence and disable:
  - TIMEOUT=16, deliver the next byte exactly in the expiry cycle → no o_frame_err, frame completes.
  - TIMEOUT=0, 1000-cycle gap mid-frame → no abort.
- Reset mid-TX (DATA_W=32, after 2 of 4 bytes pushed) → outputs zero immediately; a fresh frame afterwards is processed correctly.

Source files
------------

// File: rtl/uart_alu_sequencer_if.sv
// rtl/uart_alu_sequencer_if.sv - RX/TX FIFO and ALU signal bundle for the command sequencer
interface uart_alu_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
);
    logic [7:0]        i_rx_data;
    logic              i_rx_empty;
    logic              o_rd;
    logic              i_tx_full;
    logic              o_wr;
    logic [7:0]        o_tx_data;
    logic [DATA_W-1:0] i_result;
    logic [DATA_W-1:0] o_op_a;
    logic [DATA_W-1:0] o_op_b;
    logic [OP_W-1:0]   o_op_code;
    logic              o_busy;
    logic              o_frame_err;

    modport master (
        input  i_rx_data, i_rx_empty, i_tx_full, i_result,
        output o_rd, o_wr, o_tx_data, o_op_a, o_op_b, o_op_code, o_busy, o_frame_err
    );

    modport slave (
        output i_rx_data, i_rx_empty, i_tx_full, i_result,
        input  o_rd, o_wr, o_tx_data, o_op_a, o_op_b, o_op_code, o_busy, o_frame_err
    );
endinterface

// File: rtl/uart_alu_sequencer.sv
// rtl/uart_alu_sequencer.sv - assembles multi-byte ALU operands from RX, commits them, streams the result to TX
module uart_alu_sequencer #(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic reset,
    uart_alu_sequencer_if.master bus
);
    localparam int NBYTES = DATA_W / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TCW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
    localparam logic [TCW-1:0] TO_LAST   = (TIMEOUT > 0) ? TCW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {RX_A, RX_B, RX_OP, CALC, TX} state_t;

    state_t            state;
    logic [BCW-1:0]    bcnt;
    logic [TCW-1:0]    tcnt;
    logic [DATA_W-1:0] stage_a, stage_b, res_reg;
    logic [DATA_W-1:0] op_a, op_b;
    logic [OP_W-1:0]   op_code;
    logic              rd, wr, busy, frame_err;
    logic [7:0]        tx_data;
    logic              rx_state, last_byte, expire;

    assign rx_state  = (state == RX_A) || (state == RX_B) || (state == RX_OP);
    assign last_byte = (bcnt == LAST_BYTE);
    // A pop cycle (rd high) always beats expiry; an idle frame start (busy low) never expires.
    assign expire    = (TIMEOUT > 0) && rx_state && busy && !rd && (tcnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RX_A;
            bcnt      <= '0;
            tcnt      <= '0;
            stage_a   <= '0;
            stage_b   <= '0;
            res_reg   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_code   <= '0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            frame_err <= 1'b0;
            case (state)
                RX_A, RX_B, RX_OP: begin
                    if (rd) begin
                        // Head byte is still valid during the pop cycle; the FIFO advances at this edge.
                        rd   <= 1'b0;
                        tcnt <= '0;
                        busy <= 1'b1;
                        if (state == RX_A) begin
                            stage_a[8*bcnt +: 8] <= bus.i_rx_data;
                            bcnt  <= last_byte ? '0 : bcnt + 1'b1;
                            state <= last_byte ? RX_B : RX_A;
                        end else if (state == RX_B) begin
                            stage_b[8*bcnt +: 8] <= bus.i_rx_data;
                            bcnt  <= last_byte ? '0 : bcnt + 1'b1;
                            state <= last_byte ? RX_OP : RX_B;
                        end else begin
                            op_a    <= stage_a;
                            op_b    <= stage_b;
                            op_code <= bus.i_rx_data[OP_W-1:0];
                            bcnt    <= '0;
                            state   <= CALC;
                        end
                    end else if (expire) begin
                        frame_err <= 1'b1;
                        state     <= RX_A;
                        bcnt      <= '0;
                        tcnt      <= '0;
                        busy      <= 1'b0;
                        stage_a   <= '0;
                        stage_b   <= '0;
                        rd        <= !bus.i_rx_empty;
                    end else begin
                        rd <= !bus.i_rx_empty;
                        if (busy && TIMEOUT > 0) tcnt <= tcnt + 1'b1;
                    end
                end
                CALC: begin
                    res_reg <= bus.i_result;
                    tx_data <= bus.i_result[7:0];
                    wr      <= !bus.i_tx_full;
                    bcnt    <= '0;
                    state   <= TX;
                end
                TX: begin
                    // A push is always followed by an idle cycle so i_tx_full reflects the previous push.
                    if (wr) begin
                        wr <= 1'b0;
                        if (last_byte) begin
                            state <= RX_A;
                            bcnt  <= '0;
                            tcnt  <= '0;
                            busy  <= 1'b0;
                        end else begin
                            bcnt    <= bcnt + 1'b1;
                            tx_data <= res_reg[8*(int'(bcnt) + 1) +: 8];
                        end
                    end else begin
                        wr <= !bus.i_tx_full;
                    end
                end
                default: state <= RX_A;
            endcase
        end
    end

    assign bus.o_rd        = rd;
    assign bus.o_wr        = wr;
    assign bus.o_tx_data   = tx_data;
    assign bus.o_op_a      = op_a;
    assign bus.o_op_b      = op_b;
    assign bus.o_op_code   = op_code;
    assign bus.o_busy      = busy;
    assign bus.o_frame_err = frame_err;
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb/tb_uart_alu_sequencer.sv - directed bench for uart_alu_sequencer at 8/16/32-bit widths
module tb_uart_alu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_full = 1'b0;
    always #5 clk = ~clk;

    uart_alu_sequencer_if #(.DATA_W(8),  .OP_W(6)) if8 ();
    uart_alu_sequencer_if #(.DATA_W(16), .OP_W(6)) if16 ();
    uart_alu_sequencer_if #(.DATA_W(32), .OP_W(6)) if32 ();

    uart_alu_sequencer #(.DATA_W(8),  .OP_W(6), .TIMEOUT(16)) u8  (.clk(clk), .reset(rst), .bus(if8.master));
    uart_alu_sequencer #(.DATA_W(16), .OP_W(6), .TIMEOUT(0))  u16 (.clk(clk), .reset(rst), .bus(if16.master));
    uart_alu_sequencer #(.DATA_W(32), .OP_W(6), .TIMEOUT(16)) u32 (.clk(clk), .reset(rst), .bus(if32.master));

    // ALU stub: opcode 0x21 subtracts, everything else adds
    assign if8.i_result  = (if8.o_op_code  == 6'h21) ? if8.o_op_a  - if8.o_op_b  : if8.o_op_a  + if8.o_op_b;
    assign if16.i_result = (if16.o_op_code == 6'h21) ? if16.o_op_a - if16.o_op_b : if16.o_op_a + if16.o_op_b;
    assign if32.i_result = (if32.o_op_code == 6'h21) ? if32.o_op_a - if32.o_op_b : if32.o_op_a + if32.o_op_b;
    assign if8.i_tx_full  = tx_full;
    assign if16.i_tx_full = tx_full;
    assign if32.i_tx_full = tx_full;

    logic [7:0] q8[$], q16[$], q32[$];
    logic [7:0] o8[$], o16[$], o32[$];
    int p8 = 0, p16 = 0, p32 = 0;
    int total = 0, bad = 0;

    task automatic refresh();
        if8.i_rx_empty  = (p8 >= q8.size());
        if8.i_rx_data   = (p8 < q8.size()) ? q8[p8] : 8'h00;
        if16.i_rx_empty = (p16 >= q16.size());
        if16.i_rx_data  = (p16 < q16.size()) ? q16[p16] : 8'h00;
        if32.i_rx_empty = (p32 >= q32.size());
        if32.i_rx_data  = (p32 < q32.size()) ? q32[p32] : 8'h00;
    endtask

    // Show-ahead RX FIFOs and TX capture, owned by this one process
    always begin
        @(posedge clk);
        if (if8.o_rd  && p8  < q8.size())  p8++;
        if (if16.o_rd && p16 < q16.size()) p16++;
        if (if32.o_rd && p32 < q32.size()) p32++;
        if (if8.o_wr)  o8.push_back(if8.o_tx_data);
        if (if16.o_wr) o16.push_back(if16.o_tx_data);
        if (if32.o_wr) o32.push_back(if32.o_tx_data);
        #1 refresh();
        @(negedge clk);
        #1 refresh();
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam int S_A = 0, S_B = 1, S_OP = 2, S_BUSY = 3, S_RD = 4, S_WR = 5, S_ERR = 6, S_TXD = 7;

    function automatic logic [31:0] sig(int w, int k);
        logic [31:0] v[8];
        case (w)
            8:  v = '{32'(if8.o_op_a), 32'(if8.o_op_b), 32'(if8.o_op_code), 32'(if8.o_busy),
                      32'(if8.o_rd), 32'(if8.o_wr), 32'(if8.o_frame_err), 32'(if8.o_tx_data)};
            16: v = '{32'(if16.o_op_a), 32'(if16.o_op_b), 32'(if16.o_op_code), 32'(if16.o_busy),
                      32'(if16.o_rd), 32'(if16.o_wr), 32'(if16.o_frame_err), 32'(if16.o_tx_data)};
            default: v = '{if32.o_op_a, if32.o_op_b, 32'(if32.o_op_code), 32'(if32.o_busy),
                      32'(if32.o_rd), 32'(if32.o_wr), 32'(if32.o_frame_err), 32'(if32.o_tx_data)};
        endcase
        return v[k];
    endfunction

    function automatic int osize(int w);
        return (w == 8) ? o8.size() : (w == 16) ? o16.size() : o32.size();
    endfunction

    function automatic logic [31:0] ores(int w, int base);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < w / 8; i++) begin
            logic [7:0] b;
            b = (w == 8) ? o8[base+i] : (w == 16) ? o16[base+i] : o32[base+i];
            r[8*i +: 8] = b;
        end
        return r;
    endfunction

    task automatic push(int w, logic [7:0] b);
        if (w == 8) q8.push_back(b);
        else if (w == 16) q16.push_back(b);
        else q32.push_back(b);
    endtask

    task automatic push_word(int w, logic [31:0] v);
        for (int i = 0; i < w / 8; i++) push(w, v[8*i +: 8]);
    endtask

    task automatic wait_done(int w, int base, output int ok);
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (osize(w) - base == w / 8 && sig(w, S_BUSY) == 0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_pops(int w, int n, output int ok);
        int seen = 0;
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sig(w, S_RD) == 1) seen++;
            if (seen == n) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic run_frame(string tag, int w, logic [31:0] a, logic [31:0] b, logic [7:0] opb,
                             logic [5:0] eop, logic [31:0] eres);
        int base, ok;
        base = osize(w);
        push_word(w, a);
        push_word(w, b);
        push(w, opb);
        wait_done(w, base, ok);
        check({tag, " done"}, 32'(ok), 32'd1);
        repeat (6) @(negedge clk);
        check({tag, " op_a"}, sig(w, S_A), a);
        check({tag, " op_b"}, sig(w, S_B), b);
        check({tag, " op_code"}, sig(w, S_OP), 32'(eop));
        check({tag, " pushes"}, 32'(osize(w) - base), 32'(w / 8));
        if (ok) check({tag, " result"}, ores(w, base), eres);
    endtask

    typedef struct {
        int          w;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  opb;
        logic [5:0]  eop;
        logic [31:0] eres;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ok, base, t_op, t_wr, nrd, nwr, nerr, t_err, stable;
        logic [31:0] txd0;

        vecs[0] = '{8,  32'h05,       32'h03,       8'h20, 6'h20, 32'h08};
        vecs[1] = '{16, 32'h1234,     32'h0001,     8'hE0, 6'h20, 32'h1235};
        vecs[2] = '{16, 32'hFFFF,     32'h0002,     8'h20, 6'h20, 32'h0001};
        vecs[3] = '{8,  32'h10,       32'h20,       8'hE1, 6'h21, 32'hF0};
        vecs[4] = '{32, 32'h12345678, 32'h11111111, 8'h20, 6'h20, 32'h23456789};
        vecs[5] = '{32, 32'h0,        32'h1,        8'h61, 6'h21, 32'hFFFFFFFF};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst rd",  sig(8, S_RD), 0);
        check("rst wr",  sig(8, S_WR), 0);
        check("rst busy", sig(8, S_BUSY), 0);
        check("rst err", sig(8, S_ERR), 0);
        check("rst txd", sig(32, S_TXD), 0);
        check("rst op_a", sig(32, S_A), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].eop, vecs[i].eres);

        // Opcode pop to first push latency
        base = osize(8); nrd = 0; t_op = -1; t_wr = -1;
        push(8, 8'h05); push(8, 8'h03); push(8, 8'h20);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (sig(8, S_RD) == 1) begin nrd++; if (nrd == 3) t_op = c; end
            if (sig(8, S_WR) == 1 && t_wr < 0) t_wr = c;
            if (osize(8) - base == 1 && sig(8, S_BUSY) == 0) break;
        end
        check("latency", 32'(t_wr - t_op), 32'd2);
        check("latency result", 32'(osize(8) - base), 32'd1);

        // TX backpressure
        tx_full = 1'b1;
        base = osize(8);
        push(8, 8'h07); push(8, 8'h01); push(8, 8'h20);
        wait_pops(8, 3, ok);
        check("bp pops", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
        txd0 = sig(8, S_TXD); nwr = 0; stable = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sig(8, S_WR) == 1) nwr++;
            if (sig(8, S_TXD) != txd0) stable = 0;
        end
        check("bp no wr", 32'(nwr), 32'd0);
        check("bp stable", 32'(stable), 32'd1);
        check("bp txd", txd0, 32'h08);
        tx_full = 1'b0;
        wait_done(8, base, ok);
        repeat (5) @(negedge clk);
        check("bp pushes", 32'(osize(8) - base), 32'd1);
        if (osize(8) > base) check("bp byte", 32'(o8[base]), 32'h08);

        // Timeout abort: pulse lands 16 edges after the pop edge
        push(8, 8'h05);
        wait_pops(8, 1, ok);
        t_err = -1; nerr = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (sig(8, S_ERR) == 1) begin nerr++; if (t_err < 0) t_err = c; end
        end
        check("to cycle", 32'(t_err), 32'd17);
        check("to pulses", 32'(nerr), 32'd1);
        check("to op_a held", sig(8, S_A), 32'h07);
        check("to busy", sig(8, S_BUSY), 0);
        run_frame("to next", 8, 32'h02, 32'h02, 8'h20, 6'h20, 32'h04);

        // Next byte delivered in the expiry cycle
        base = osize(8);
        push(8, 8'h05);
        wait_pops(8, 1, ok);
        repeat (15) @(negedge clk);
        push(8, 8'h03);
        nerr = 0; ok = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (sig(8, S_ERR) == 1) nerr++;
            if (c == 4) push(8, 8'h20);
            if (osize(8) - base == 1 && sig(8, S_BUSY) == 0) begin ok = 1; break; end
        end
        check("coin no err", 32'(nerr), 32'd0);
        check("coin done", 32'(ok), 32'd1);
        check("coin op_b", sig(8, S_B), 32'h03);
        if (ok) check("coin result", ores(8, base), 32'h08);

        // TIMEOUT=0: long gap mid-frame
        base = osize(16); nerr = 0;
        push(16, 8'h34);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (sig(16, S_ERR) == 1) nerr++;
        end
        check("gap no err", 32'(nerr), 32'd0);
        check("gap busy", sig(16, S_BUSY), 1);
        push(16, 8'h12); push_word(16, 32'h0001); push(16, 8'hE0);
        wait_done(16, base, ok);
        check("gap done", 32'(ok), 32'd1);
        if (ok) check("gap result", ores(16, base), 32'h1235);

        // Reset in the middle of a 4-byte result
        base = osize(32); ok = 0;
        push_word(32, 32'h01020304); push_word(32, 32'h0); push(32, 8'h20);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (osize(32) - base == 2) begin ok = 1; break; end
        end
        check("mid tx reached", 32'(ok), 32'd1);
        if (ok) check("mid tx bytes", ores(32, base) & 32'h0000FFFF, 32'h00000304);
        rst = 1'b1;
        #1;
        check("mrst op_a", sig(32, S_A), 0);
        check("mrst wr", sig(32, S_WR), 0);
        check("mrst txd", sig(32, S_TXD), 0);
        check("mrst busy", sig(32, S_BUSY), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("mrst no resend", 32'(osize(32) - base), 32'd2);
        run_frame("post rst", 32, 32'h000000FF, 32'h00000001, 8'h20, 6'h20, 32'h00000100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
